// File: rtl/ball_pkg.sv
// Shared definitions for the ball game controller: state encoding, screen
// geometry, coordinate widths and the step-event record.
package ball_pkg;

    localparam int unsigned SCREEN_W = 1024;
    localparam int unsigned SCREEN_H = 768;
    localparam int unsigned COORD_W  = 12;
    localparam int unsigned CMP_W    = 13;
    localparam int unsigned BRICK_N  = 16;
    localparam int unsigned LIVES_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        LOST = 2'd2,
        OVER = 2'd3
    } state_e;

    // Events detected on a ball step, before priority is applied
    typedef struct packed {
        logic miss;
        logic paddle;
        logic brick;
        logic wall_l;
        logic wall_r;
        logic wall_t;
    } step_evt_t;

    // Isolate the lowest set bit (one-hot result, zero when v is zero)
    function automatic logic [BRICK_N-1:0] lowest_set(input logic [BRICK_N-1:0] v);
        lowest_set = v & (~v + BRICK_N'(1));
    endfunction

endpackage

// File: rtl/ball_game_ctrl_if.sv
// Bus between the game controller (slave side) and the ball/brick/mouse
// datapath (master side).
interface ball_game_ctrl_if
    import ball_pkg::*;
;

    logic                  launch;
    logic [BRICK_N-1:0]    collision_det;
    logic [COORD_W-1:0]    ball_x;
    logic [COORD_W-1:0]    ball_y;
    logic [COORD_W-1:0]    mouse_x;
    logic [COORD_W-1:0]    mouse_y;

    logic                  step_en;
    logic                  dir_x;
    logic                  dir_y;
    logic                  ball_load;
    logic [BRICK_N-1:0]    brick_clr;
    logic [LIVES_W-1:0]    lives;
    logic                  game_over;

    modport master (
        output launch, collision_det, ball_x, ball_y, mouse_x, mouse_y,
        input  step_en, dir_x, dir_y, ball_load, brick_clr, lives, game_over
    );

    modport slave (
        input  launch, collision_det, ball_x, ball_y, mouse_x, mouse_y,
        output step_en, dir_x, dir_y, ball_load, brick_clr, lives, game_over
    );

endinterface

// File: rtl/ball_tick_gen.sv
// Ball step tick generator. While reload is high the counter is held at
// div-1; otherwise it counts down and step_en is high for the one cycle in
// which the counter reads zero, after which it reloads. div must be >= 2.
module ball_tick_gen #(
    parameter int unsigned DIV_W    = 20,
    parameter int unsigned DIV_INIT = 800000
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             reload,
    input  logic [DIV_W-1:0] div,
    output logic             step_en
);

    logic [DIV_W-1:0] cnt_q;
    logic             step_q;

    // Down-counter; the pulse is registered one cycle ahead of the zero count
    always_ff @(posedge pclk) begin
        if (reset) begin
            cnt_q  <= DIV_W'(DIV_INIT - 1);
            step_q <= 1'b0;
        end else if (reload) begin
            cnt_q  <= div - DIV_W'(1);
            step_q <= 1'b0;
        end else begin
            step_q <= (cnt_q == DIV_W'(1));
            if (cnt_q == '0) begin
                cnt_q <= div - DIV_W'(1);
            end else begin
                cnt_q <= cnt_q - DIV_W'(1);
            end
        end
    end

    assign step_en = step_q;

endmodule

// File: rtl/ball_game_ctrl.sv
// Breakout-style game controller: serves the ball, steps it at a fixed
// rate, resolves miss/paddle/brick/wall events on each step and tracks lives.
// Optional feature macro BALL_SPEEDUP_EN: every 8th brick clear shortens the
// step period by 1/8, floored at TICK_DIV/4; restored on a lost ball/restart.
module ball_game_ctrl
    import ball_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 800000,
    parameter int unsigned LIVES_INIT = 3,
    parameter int unsigned PADDLE_W   = 200,
    parameter int unsigned BALL_R     = 10
) (
    input  logic            pclk,
    input  logic            reset,
    ball_game_ctrl_if.slave bus
);

    localparam int unsigned DIV_W = $clog2(TICK_DIV + 1);

    state_e             state_q;
    logic               launch_q;
    logic               rst_seen_q;
    logic               dir_x_q;
    logic               dir_y_q;
    logic               ball_load_q;
    logic [BRICK_N-1:0] brick_clr_q;
    logic [LIVES_W-1:0] lives_q;
    logic               game_over_q;

    logic               launch_rise;
    logic               step_en;
    logic               tick_reload;
    logic [DIV_W-1:0]   div_act;

    logic [CMP_W-1:0]   bx;
    logic [CMP_W-1:0]   by;
    logic [CMP_W-1:0]   mx;
    logic [CMP_W-1:0]   my;
    logic [CMP_W-1:0]   rad;
    logic               over_x;
    step_evt_t          evt;

    assign launch_rise = bus.launch & ~launch_q;
    assign tick_reload = (state_q != PLAY);

    // Widen to 13 bits so right-edge and paddle sums cannot wrap
    assign bx  = CMP_W'(bus.ball_x);
    assign by  = CMP_W'(bus.ball_y);
    assign mx  = CMP_W'(bus.mouse_x);
    assign my  = CMP_W'(bus.mouse_y);
    assign rad = CMP_W'(BALL_R);

    // Raw event detection from the current ball, paddle and brick inputs
    always_comb begin
        evt        = '0;
        over_x     = (mx <= bx) && (bx <= mx + CMP_W'(PADDLE_W));
        evt.miss   = (by + rad >= CMP_W'(SCREEN_H - 1)) && !over_x;
        evt.paddle = dir_y_q && (by + rad >= my) && over_x;
        evt.brick  = |bus.collision_det;
        evt.wall_l = (bx == rad);
        evt.wall_r = (bx + rad == CMP_W'(SCREEN_W - 1));
        evt.wall_t = (by == rad);
    end

`ifdef BALL_SPEEDUP_EN
    localparam int unsigned DIV_MIN_RAW = TICK_DIV / 4;
    localparam int unsigned DIV_MIN     = (DIV_MIN_RAW < 2) ? 2 : DIV_MIN_RAW;

    logic [DIV_W-1:0] div_q;
    logic [2:0]       hits_q;
    logic [DIV_W-1:0] div_dec;

    // Candidate shortened divisor, clamped at the floor
    always_comb begin
        div_dec = div_q - (div_q >> 3);
        if (div_dec < DIV_W'(DIV_MIN)) begin
            div_dec = DIV_W'(DIV_MIN);
        end
    end

    // Brick-clear counter and active divisor
    always_ff @(posedge pclk) begin
        if (reset) begin
            div_q  <= DIV_W'(TICK_DIV);
            hits_q <= '0;
        end else if ((state_q == LOST) || ((state_q == OVER) && launch_rise)) begin
            div_q  <= DIV_W'(TICK_DIV);
            hits_q <= '0;
        end else if ((state_q == PLAY) && step_en && !evt.miss && evt.brick) begin
            hits_q <= hits_q + 3'd1;
            if (hits_q == 3'd7) begin
                div_q <= div_dec;
            end
        end
    end

    assign div_act = div_q;
`else
    assign div_act = DIV_W'(TICK_DIV);
`endif

    ball_tick_gen #(
        .DIV_W    (DIV_W),
        .DIV_INIT (TICK_DIV)
    ) u_tick (
        .pclk    (pclk),
        .reset   (reset),
        .reload  (tick_reload),
        .div     (div_act),
        .step_en (step_en)
    );

    // Game FSM with registered outputs; step effects appear the next cycle
    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q     <= IDLE;
            launch_q    <= 1'b1;
            rst_seen_q  <= 1'b1;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b0;
            ball_load_q <= 1'b0;
            brick_clr_q <= '0;
            lives_q     <= LIVES_W'(LIVES_INIT);
            game_over_q <= 1'b0;
        end else begin
            launch_q    <= bus.launch;
            rst_seen_q  <= 1'b0;
            ball_load_q <= rst_seen_q;
            brick_clr_q <= '0;
            case (state_q)
                IDLE: begin
                    if (launch_rise) begin
                        state_q <= PLAY;
                        dir_x_q <= 1'b1;
                        dir_y_q <= 1'b0;
                    end
                end
                PLAY: begin
                    if (step_en) begin
                        if (evt.miss) begin
                            state_q     <= LOST;
                            lives_q     <= lives_q - LIVES_W'(1);
                            ball_load_q <= 1'b1;
                        end else begin
                            if (evt.brick) begin
                                brick_clr_q <= lowest_set(bus.collision_det);
                            end
                            if (evt.paddle) begin
                                dir_y_q <= 1'b0;
                            end else if (evt.brick) begin
                                dir_y_q <= ~dir_y_q;
                            end else if (evt.wall_t) begin
                                dir_y_q <= 1'b1;
                            end
                            if (evt.wall_l) begin
                                dir_x_q <= 1'b1;
                            end else if (evt.wall_r) begin
                                dir_x_q <= 1'b0;
                            end
                        end
                    end
                end
                LOST: begin
                    state_q     <= (lives_q == '0) ? OVER : IDLE;
                    game_over_q <= (lives_q == '0);
                end
                OVER: begin
                    if (launch_rise) begin
                        state_q     <= IDLE;
                        lives_q     <= LIVES_W'(LIVES_INIT);
                        ball_load_q <= 1'b1;
                        game_over_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.step_en   = step_en;
    assign bus.dir_x     = dir_x_q;
    assign bus.dir_y     = dir_y_q;
    assign bus.ball_load = ball_load_q;
    assign bus.brick_clr = brick_clr_q;
    assign bus.lives     = lives_q;
    assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_ball_game_ctrl.sv
// Testbench for ball_game_ctrl: directed vector table, multi-cycle corner
// sequences and randomized steps checked against a rule-level model.
module tb_ball_game_ctrl;
    import ball_pkg::*;

`ifdef BALL_SPEEDUP_EN
    localparam int TB_DIV = 64;
`else
    localparam int TB_DIV = 4;
`endif
    localparam int TB_LIVES = 3;
    localparam int TB_PW    = 200;
    localparam int TB_R     = 10;
    localparam int BUDGET   = 4 * TB_DIV + 16;

    typedef struct {
        int          bx;
        int          by;
        int          mx;
        int          my;
        logic [15:0] coll;
    } stim_t;

    typedef struct {
        stim_t       s;
        bit          edx;
        bit          edy;
        logic [15:0] eclr;
        bit          elost;
    } vec_t;

    logic pclk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    ball_game_ctrl_if bus();

    ball_game_ctrl #(
        .TICK_DIV   (TB_DIV),
        .LIVES_INIT (TB_LIVES),
        .PADDLE_W   (TB_PW),
        .BALL_R     (TB_R)
    ) dut (
        .pclk  (pclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input stim_t s);
        bus.ball_x        = 12'(s.bx);
        bus.ball_y        = 12'(s.by);
        bus.mouse_x       = 12'(s.mx);
        bus.mouse_y       = 12'(s.my);
        bus.collision_det = s.coll;
    endtask

    task automatic drive_safe();
        stim_t s;
        s = '{500, 400, 100, 760, 16'h0000};
        drive(s);
    endtask

    task automatic drive_miss();
        stim_t s;
        s = '{50, 757, 100, 760, 16'h0000};
        drive(s);
    endtask

    // Cycles (negedges) until step_en is seen; 0 if the budget runs out
    task automatic cycles_to_step(output int n);
        n = 0;
        for (int i = 1; i <= BUDGET; i++) begin
            @(negedge pclk);
            if (bus.step_en) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_step();
        int n;
        cycles_to_step(n);
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL step_timeout: no step_en within %0d cycles", BUDGET);
        end
    endtask

    // Rising launch edge; returns at the negedge where launch goes high
    task automatic launch_pulse();
        bus.launch = 1'b0;
        @(negedge pclk);
        bus.launch = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge pclk);
        reset = 1'b0;
        repeat (2) @(negedge pclk);
    endtask

    // Rule-level reference for one ball step
    function automatic void model_step(input stim_t s, inout bit dx, inout bit dy,
                                       output logic [15:0] clr, output bit lost);
        bit over;
        over = (s.mx <= s.bx) && (s.bx <= s.mx + TB_PW);
        clr  = 16'h0000;
        lost = 1'b0;
        if ((s.by + TB_R >= int'(SCREEN_H) - 1) && !over) begin
            lost = 1'b1;
            return;
        end
        if (dy && (s.by + TB_R >= s.my) && over) dy = 1'b0;
        else if (s.coll != 16'h0000)             dy = !dy;
        else if (s.by - TB_R == 0)               dy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (s.coll[i]) begin
                clr = 16'h0001 << i;
                break;
            end
        end
        if (s.bx - TB_R == 0)                    dx = 1'b1;
        else if (s.bx + TB_R == int'(SCREEN_W) - 1) dx = 1'b0;
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[14];
        int          n;
        int          steps;
        logic [15:0] clr_seen;
        bit          mdx;
        bit          mdy;
        int          mlives;
        stim_t       s;
        logic [15:0] eclr;
        bit          elost;

        tbl[0]  = '{'{500,  400, 100,  760, 16'h0000}, 1, 0, 16'h0000, 0};
        tbl[1]  = '{'{500,  400, 100,  760, 16'h0014}, 1, 1, 16'h0004, 0};
        tbl[2]  = '{'{500,  400, 100,  760, 16'h0010}, 1, 0, 16'h0010, 0};
        tbl[3]  = '{'{500,  10,  100,  760, 16'h0000}, 1, 1, 16'h0000, 0};
        tbl[4]  = '{'{1013, 400, 100,  760, 16'h0000}, 0, 1, 16'h0000, 0};
        tbl[5]  = '{'{10,   400, 100,  760, 16'h0000}, 1, 1, 16'h0000, 0};
        tbl[6]  = '{'{500,  10,  100,  760, 16'h8000}, 1, 0, 16'h8000, 0};
        tbl[7]  = '{'{1013, 400, 100,  760, 16'h0001}, 0, 1, 16'h0001, 0};
        tbl[8]  = '{'{300,  757, 100,  760, 16'h0000}, 0, 0, 16'h0000, 0};
        tbl[9]  = '{'{500,  10,  100,  760, 16'h0000}, 0, 1, 16'h0000, 0};
        tbl[10] = '{'{4050, 757, 4000, 700, 16'h0000}, 0, 0, 16'h0000, 0};
        tbl[11] = '{'{500,  400, 100,  760, 16'h0100}, 0, 1, 16'h0100, 0};
        tbl[12] = '{'{300,  757, 100,  760, 16'h0200}, 0, 0, 16'h0200, 0};
        tbl[13] = '{'{50,   757, 100,  760, 16'h0000}, 0, 0, 16'h0000, 1};

        // Reset with launch held high
        reset      = 1'b1;
        bus.launch = 1'b1;
        drive_safe();
        repeat (3) @(negedge pclk);
        check("rst_step_en",   32'(bus.step_en),   32'd0);
        check("rst_dir_x",     32'(bus.dir_x),     32'd1);
        check("rst_dir_y",     32'(bus.dir_y),     32'd0);
        check("rst_brick_clr", 32'(bus.brick_clr), 32'd0);
        check("rst_game_over", 32'(bus.game_over), 32'd0);
        check("rst_lives",     32'(bus.lives),     32'(TB_LIVES));
        check("rst_ball_load", 32'(bus.ball_load), 32'd0);
        reset = 1'b0;
        @(negedge pclk);
        check("post_rst_load_hi", 32'(bus.ball_load), 32'd1);
        @(negedge pclk);
        check("post_rst_load_lo", 32'(bus.ball_load), 32'd0);
        steps = 0;
        repeat (3 * TB_DIV) begin
            @(negedge pclk);
            if (bus.step_en) steps++;
        end
        check("held_launch_no_serve", 32'(steps), 32'd0);

        // Serve and step cadence
        launch_pulse();
        for (int c = 1; c <= 3 * TB_DIV; c++) begin
            @(negedge pclk);
            check($sformatf("cadence_c%0d", c), 32'(bus.step_en), 32'((c % TB_DIV) == 0));
        end
        check("serve_dir_y", 32'(bus.dir_y), 32'd0);
        check("serve_dir_x", 32'(bus.dir_x), 32'd1);

        // Directed step table
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].s);
            wait_step();
            @(negedge pclk);
            check($sformatf("tbl%0d_dir_x", i),     32'(bus.dir_x),     32'(tbl[i].edx));
            check($sformatf("tbl%0d_dir_y", i),     32'(bus.dir_y),     32'(tbl[i].edy));
            check($sformatf("tbl%0d_brick_clr", i), 32'(bus.brick_clr), 32'(tbl[i].eclr));
            check($sformatf("tbl%0d_ball_load", i), 32'(bus.ball_load), 32'(tbl[i].elost));
            check($sformatf("tbl%0d_lives", i),     32'(bus.lives),     32'(tbl[i].elost ? TB_LIVES - 1 : TB_LIVES));
            drive_safe();
        end
        @(negedge pclk);
        check("tbl_after_lost_game_over", 32'(bus.game_over), 32'd0);
        cycles_to_step(n);
        check("tbl_after_lost_idle", 32'(n), 32'd0);

        // Three misses to game over, then restart
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive_miss();
            launch_pulse();
            wait_step();
            @(negedge pclk);
            check($sformatf("miss%0d_lives", k),     32'(bus.lives),     32'(TB_LIVES - 1 - k));
            check($sformatf("miss%0d_ball_load", k), 32'(bus.ball_load), 32'd1);
            @(negedge pclk);
            check($sformatf("miss%0d_game_over", k), 32'(bus.game_over), 32'(k == 2));
        end
        drive_safe();
        launch_pulse();
        @(negedge pclk);
        check("restart_lives",     32'(bus.lives),     32'(TB_LIVES));
        check("restart_ball_load", 32'(bus.ball_load), 32'd1);
        check("restart_game_over", 32'(bus.game_over), 32'd0);
        cycles_to_step(n);
        check("restart_idle", 32'(n), 32'd0);

`ifdef BALL_SPEEDUP_EN
        // Eight clears shorten the period; a miss restores it
        s = '{500, 400, 100, 760, 16'h0001};
        drive(s);
        launch_pulse();
        for (int k = 0; k < 8; k++) wait_step();
        @(negedge pclk);
        drive_safe();
        wait_step();
        cycles_to_step(n);
        check("speedup_period", 32'(n), 32'(TB_DIV - TB_DIV / 8));
        @(negedge pclk);
        drive_miss();
        wait_step();
        @(negedge pclk);
        drive_safe();
        @(negedge pclk);
        launch_pulse();
        cycles_to_step(n);
        check("speedup_restored", 32'(n), 32'(TB_DIV));
`endif

        // Reset in the cycle a step with a brick hit would occur
        s = '{500, 400, 100, 760, 16'h0004};
        drive(s);
        launch_pulse();
        repeat (TB_DIV - 1) @(negedge pclk);
        reset = 1'b1;
        @(negedge pclk);
        check("midrst_step_en",   32'(bus.step_en),   32'd0);
        check("midrst_brick_clr", 32'(bus.brick_clr), 32'd0);
        @(negedge pclk);
        reset    = 1'b0;
        steps    = 0;
        clr_seen = 16'h0000;
        repeat (2 * TB_DIV) begin
            @(negedge pclk);
            if (bus.step_en) steps++;
            clr_seen = clr_seen | bus.brick_clr;
        end
        check("midrst_no_step",  32'(steps),    32'd0);
        check("midrst_no_clear", 32'(clr_seen), 32'd0);
        check("midrst_lives",    32'(bus.lives), 32'(TB_LIVES));
        drive_safe();

        // Randomized steps against the reference model
        mdx    = 1'b1;
        mdy    = 1'b0;
        mlives = TB_LIVES;
        launch_pulse();
        for (int it = 0; it < 60; it++) begin
            s.mx = int'($urandom_range(0, 4095));
            case ($urandom_range(0, 3))
                0:       s.bx = TB_R;
                1:       s.bx = 1023 - TB_R;
                2:       s.bx = int'($urandom_range(0, 1023));
                default: s.bx = s.mx + int'($urandom_range(0, TB_PW + 2));
            endcase
            if (s.bx > 4095) s.bx = 4095;
            case ($urandom_range(0, 3))
                0:       s.by = TB_R;
                1:       s.by = 757;
                2:       s.by = int'($urandom_range(750, 760));
                default: s.by = int'($urandom_range(20, 700));
            endcase
            case ($urandom_range(0, 2))
                0:       s.my = 760;
                1:       s.my = int'($urandom_range(0, 4095));
                default: s.my = 700;
            endcase
            s.coll = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h0000;
            drive(s);
            wait_step();
            model_step(s, mdx, mdy, eclr, elost);
            if (elost) mlives--;
            @(negedge pclk);
            check($sformatf("rnd%0d_ball_load", it), 32'(bus.ball_load), 32'(elost));
            check($sformatf("rnd%0d_lives", it),     32'(bus.lives),     32'(mlives));
            if (!elost) begin
                check($sformatf("rnd%0d_dir_x", it),     32'(bus.dir_x),     32'(mdx));
                check($sformatf("rnd%0d_dir_y", it),     32'(bus.dir_y),     32'(mdy));
                check($sformatf("rnd%0d_brick_clr", it), 32'(bus.brick_clr), 32'(eclr));
            end else begin
                drive_safe();
                @(negedge pclk);
                check($sformatf("rnd%0d_game_over", it), 32'(bus.game_over), 32'(mlives == 0));
                if (mlives == 0) begin
                    launch_pulse();
                    @(negedge pclk);
                    check($sformatf("rnd%0d_restart_lives", it), 32'(bus.lives), 32'(TB_LIVES));
                    mlives = TB_LIVES;
                end
                mdx = 1'b1;
                mdy = 1'b0;
                launch_pulse();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ball_game_ctrl.md
BALL_GAME_CTRL -- requirements
Module: ball_game_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 800000, meaning pclk cycles per ball step.
REQ-002 The block SHALL have parameter LIVES_INIT, default 3, meaning lives loaded at reset and at restart.
REQ-003 The block SHALL have parameter PADDLE_W, default 200, meaning paddle width in pixels.
REQ-004 The block SHALL have parameter BALL_R, default 10, meaning ball radius in pixels.
REQ-005 The block SHALL have port pclk, input, 1, clock; reset, input, 1, synchronous, active-high.
REQ-006 The block SHALL have port launch, input, 1, meaning mouse button; serve request, level.
REQ-007 The block SHALL have port collision_det, input, 16, meaning one bit per brick hit this cycle.
REQ-008 The block SHALL have ports ball_x and ball_y, input, 12 each, meaning ball centre position.
REQ-009 The block SHALL have ports mouse_x and mouse_y, input, 12 each, meaning paddle left edge and top.
REQ-010 The block SHALL have port step_en, output, 1, meaning one-cycle pulse that moves the ball one pixel per axis.
REQ-011 The block SHALL have ports dir_x and dir_y, output, 1 each, meaning 1 = +x and 1 = +y (down).
REQ-012 The block SHALL have port ball_load, output, 1, meaning one-cycle pulse that loads the ball start position.
REQ-013 The block SHALL have port brick_clr, output, 16, meaning one-hot one-cycle brick clear.
REQ-014 The block SHALL have ports lives (output, 2, remaining lives) and game_over (output, 1, level).

Function
REQ-015 The FSM SHALL have states IDLE, PLAY, LOST and OVER, encoded in 2 bits.
- IDLE: ball held; step_en=0.
- IDLE->PLAY on a launch rising edge; dir_y=0 (up), dir_x=1.
REQ-016 The tick counter SHALL load TICK_DIV-1 on entry to PLAY and decrement each cycle in PLAY; step_en SHALL pulse in the cycle it reads 0, then the counter SHALL reload.
REQ-017 Events SHALL be evaluated only in the step_en cycle, with direction updates visible the next cycle; priority SHALL be miss > paddle > brick > wall.
- Miss: ball_y+BALL_R >= 767 and not over paddle -> LOST.
- Paddle: dir_y=1, ball_y+BALL_R >= mouse_y and mouse_x <= ball_x <= mouse_x+PADDLE_W -> dir_y=0.
- Brick: collision_det != 0 -> dir_y toggles once; brick_clr = lowest set bit.
- Wall: ball_x-BALL_R==0 -> dir_x=1; ball_x+BALL_R==1023 -> dir_x=0; ball_y-BALL_R==0 -> dir_y=1.
REQ-018 Brick and wall events in the same step SHALL both apply, but each axis SHALL flip at most once per step.
REQ-019 Multiple collision_det bits SHALL clear only the lowest index per step; the remaining bits SHALL be serviced on later steps.
REQ-020 LOST SHALL last 1 cycle: lives decrements and ball_load pulses, then the FSM enters IDLE if lives>0, else OVER.
REQ-021 OVER SHALL set game_over=1; a launch rising edge in OVER SHALL reload lives to LIVES_INIT, pulse ball_load and enter IDLE.
REQ-022 Launch edge detection SHALL use a registered copy of launch; a launch held through reset SHALL NOT serve.
REQ-023 All comparisons SHALL be 13-bit unsigned to avoid wrap, for example at mouse_x+PADDLE_W > 4095.

Reset
REQ-024 On reset the block SHALL enter IDLE with step_en=0, dir_x=1, dir_y=0, brick_clr=0, game_over=0, lives=LIVES_INIT, counter=TICK_DIV-1 and launch register=1.
REQ-025 The block SHALL pulse ball_load in the first cycle after reset deasserts.
REQ-026 A reset mid-PLAY SHALL abort any pending step, and no brick_clr SHALL issue.

Configuration
REQ-027 With macro BALL_SPEEDUP_EN defined, every 8th brick clear SHALL reduce the active divisor by divisor/8, floored at TICK_DIV/4.
REQ-028 The active divisor SHALL restore to TICK_DIV on LOST and on restart.
REQ-029 Without BALL_SPEEDUP_EN the divisor SHALL be the constant TICK_DIV and no hit counter SHALL exist.

Structure
REQ-030 Package ball_pkg SHALL hold the state encoding, SCREEN_W=1024 and SCREEN_H=768.
REQ-031 The tick generator SHALL be sub-module ball_tick_gen, with inputs reload and div and output step_en.

Verification
REQ-032 The bench SHALL cover these scenarios, with TICK_DIV=4:
- Reset, then launch 0->1: PLAY; step_en on cycles 4, 8, 12; dir_y=0.
- In PLAY, collision_det=16'h0014 at a step: brick_clr=16'h0004 that cycle; dir_y toggles once; the next step gives brick_clr=16'h0010.
- At a step, ball_y=757, dir_y=1, mouse_y=760, mouse_x=100, ball_x=300: dir_y=0, lives unchanged.
- At a step, ball_y=757, ball_x=50, mouse_x=100: LOST; lives 3->2; ball_load pulse; IDLE.
- Three misses: lives=0, game_over=1; launch edge gives lives=3, IDLE.
- With BALL_SPEEDUP_EN and TICK_DIV=64: after 8 clears the step period is 56 cycles; after a miss it is 64.
